conv2_maxpool_relu: RTL and testbench

//  Consumer of the 2nd convolution layer's 3-channel output stream (conv2 results + valid strobe).

---
 rtl/conv2_maxpool_relu.sv | 173 +++++++++++++++++
 tb/tb_conv2_maxpool_relu.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_maxpool_relu.sv
// -----------------------------------------------------------------------------
// conv2_maxpool_relu
//
// Takes the three-channel output stream of the second convolution layer. For
// each channel it does 2x2, stride-2 max-pooling and then ReLU. The input is
// an 8x8 raster frame per channel and the output is a 4x4 raster frame per
// channel. The result feeds the fully-connected stage.
//
// Pooling is streamed, so no frame buffer is needed:
//   - even column : the pixel is kept as the window's "left" sample
//   - odd column, even row : max(left, pixel) goes into a half-row line buffer
//   - odd column, odd row  : max(line buffer, left, pixel) -> ReLU -> output
//
// Ports
//   clk             in   1         clock; all state updates on the rising edge
//   rst_n           in   1         synchronous reset, ACTIVE-HIGH (1 = reset)
//   valid_in        in   1         conv_out_1..3 carry one pixel this cycle
//   conv_out_1..3   in   CONV_BIT  signed conv2 samples, channels 1..3
//   max_value_1..3  out  CONV_BIT  pooled + ReLU result, channels 1..3 (>= 0)
//   valid_out_relu  out  1         one-cycle pulse per output pixel
// -----------------------------------------------------------------------------
module conv2_maxpool_relu #(
  parameter int CONV_BIT    = 12,
  parameter int HALF_WIDTH  = 4,
  parameter int HALF_HEIGHT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [CONV_BIT-1:0] conv_out_1,
  input  logic [CONV_BIT-1:0] conv_out_2,
  input  logic [CONV_BIT-1:0] conv_out_3,
  output logic [CONV_BIT-1:0] max_value_1,
  output logic [CONV_BIT-1:0] max_value_2,
  output logic [CONV_BIT-1:0] max_value_3,
  output logic                valid_out_relu
);

  localparam int NUM_CH = 3;
  localparam int COLS   = 2 * HALF_WIDTH;
  localparam int ROWS   = 2 * HALF_HEIGHT;
  localparam int COL_W  = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int LB_W   = (HALF_WIDTH > 1) ? $clog2(HALF_WIDTH) : 1;

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

  typedef enum logic {
    ROW_EVEN = 1'b0,
    ROW_ODD  = 1'b1
  } state_t;

  // Signed maximum over the full sample width.
  function automatic logic signed [CONV_BIT-1:0] smax(
    input logic signed [CONV_BIT-1:0] a,
    input logic signed [CONV_BIT-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

  // ReLU: negative values clamp to zero; positive values pass unchanged.
  function automatic logic [CONV_BIT-1:0] relu(input logic signed [CONV_BIT-1:0] x);
    return x[CONV_BIT-1] ? '0 : x;
  endfunction

  state_t                      state, state_next;
  logic [COL_W-1:0]            col;
  logic [ROW_W-1:0]            row;
  logic [LB_W-1:0]             lb_idx;
  logic                        col_last;
  logic                        window_done;

  logic signed [CONV_BIT-1:0]  sample   [NUM_CH];
  logic signed [CONV_BIT-1:0]  left     [NUM_CH];
  logic signed [CONV_BIT-1:0]  linebuf  [NUM_CH][HALF_WIDTH];
  logic signed [CONV_BIT-1:0]  pair_max [NUM_CH];
  logic signed [CONV_BIT-1:0]  win_max  [NUM_CH];
  logic        [CONV_BIT-1:0]  pooled   [NUM_CH];

  assign sample[0] = conv_out_1;
  assign sample[1] = conv_out_2;
  assign sample[2] = conv_out_3;

  assign max_value_1 = pooled[0];
  assign max_value_2 = pooled[1];
  assign max_value_3 = pooled[2];

  // An output column pair shares one line-buffer slot.
  assign lb_idx = LB_W'(col >> 1);

  // ---------------------------------------------------------------------------
  // Row-parity FSM: next state and the decodes that follow from it
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal this block drives gets a default first, so no path
    // leaves one unassigned and no latch can be inferred.
    state_next  = state;
    col_last    = (col == COL_LAST);
    window_done = 1'b0;

    if (valid_in && col_last) begin
      state_next = (state == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
    end

    // A window is complete when its bottom-right pixel (odd row, odd col)
    // arrives.
    if (valid_in && col[0] && (state == ROW_ODD)) begin
      window_done = 1'b1;
    end
  end

  always_comb begin
    for (int ch = 0; ch < NUM_CH; ch++) begin
      pair_max[ch] = smax(left[ch], sample[ch]);
      win_max[ch]  = smax(linebuf[ch][lb_idx], pair_max[ch]);
    end
  end

  // ---------------------------------------------------------------------------
  // Control state and output registers (reset)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples values from before the edge no matter how statements are ordered.
    if (rst_n) begin
      state          <= ROW_EVEN;
      col            <= '0;
      row            <= '0;
      valid_out_relu <= 1'b0;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        pooled[ch] <= '0;
      end
    end else begin
      state          <= state_next;
      valid_out_relu <= window_done;

      if (valid_in) begin
        if (col_last) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end

      if (window_done) begin
        for (int ch = 0; ch < NUM_CH; ch++) begin
          pooled[ch] <= relu(win_max[ch]);
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Datapath storage (no reset)
  // ---------------------------------------------------------------------------
  // NOTE: left and linebuf are deliberately left unreset. The counters make
  // sure each entry is written before it is read, so a reset would only add
  // reset fan-out to what is really a small RAM.
  always_ff @(posedge clk) begin
    if (valid_in) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        if (!col[0]) begin
          left[ch] <= sample[ch];
        end else if (state == ROW_EVEN) begin
          linebuf[ch][lb_idx] <= pair_max[ch];
        end
      end
    end
  end

endmodule

// File: tb/tb_conv2_maxpool_relu.sv
// -----------------------------------------------------------------------------
// tb_conv2_maxpool_relu
//
// Directed testbench for conv2_maxpool_relu. Each frame is built as an 8x8
// table per channel. For every window the expected output is the signed
// maximum of its four pixels, followed by ReLU. Outputs are sampled 1 time
// unit after each rising edge. Every cycle is checked: a pulse appears exactly
// one cycle after each bottom-right pixel, with the expected values, and on
// every other cycle there is no pulse and the previous values are held.
// -----------------------------------------------------------------------------
module tb_conv2_maxpool_relu;

  localparam int CB = 12;

  logic          clk;
  logic          rst_n;
  logic          valid_in;
  logic [CB-1:0] conv_out_1, conv_out_2, conv_out_3;
  logic [CB-1:0] max_value_1, max_value_2, max_value_3;
  logic          valid_out_relu;

  conv2_maxpool_relu #(
    .CONV_BIT   (CB),
    .HALF_WIDTH (4),
    .HALF_HEIGHT(4)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .conv_out_1    (conv_out_1),
    .conv_out_2    (conv_out_2),
    .conv_out_3    (conv_out_3),
    .max_value_1   (max_value_1),
    .max_value_2   (max_value_2),
    .max_value_3   (max_value_3),
    .valid_out_relu(valid_out_relu)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  string         cur_test;
  int            pix      [3][8][8];
  logic [CB-1:0] last_exp [3];
  logic [CB-1:0] obs      [3];
  int            pulses;

  always_comb begin
    obs[0] = max_value_1;
    obs[1] = max_value_2;
    obs[2] = max_value_3;
  end

  // Reference value for output window (i,j) of channel ch.
  function automatic logic [CB-1:0] expect_val(int ch, int i, int j, int off);
    int m;
    m = pix[ch][2*i][2*j] + off;
    for (int dr = 0; dr < 2; dr++)
      for (int dc = 0; dc < 2; dc++)
        if (pix[ch][2*i+dr][2*j+dc] + off > m) m = pix[ch][2*i+dr][2*j+dc] + off;
    return (m < 0) ? '0 : CB'(m);
  endfunction

  // Ramp frame: ch1 = 8r+c, ch2 = -128 everywhere, ch3 = 8r+c-40.
  function automatic void fill_ramp();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        pix[0][r][c] = 8*r + c;
        pix[1][r][c] = -128;
        pix[2][r][c] = 8*r + c - 40;
      end
  endfunction

  // On cycles with no pulse, the outputs must be unchanged.
  task automatic check_idle_outputs(input int r, input int c);
    checks++;
    if (valid_out_relu !== 1'b0) begin
      errors++;
      $display("FAIL %s no_pulse pix(%0d,%0d): valid_out_relu got %b want 0", cur_test, r, c, valid_out_relu);
    end
    for (int ch = 0; ch < 3; ch++) begin
      checks++;
      if (obs[ch] !== last_exp[ch]) begin
        errors++;
        $display("FAIL %s hold pix(%0d,%0d) ch%0d: got %h want %h", cur_test, r, c, ch + 1, obs[ch], last_exp[ch]);
      end
    end
  endtask

  // Drive one pixel and check the response one cycle later.
  task automatic send_pixel(input int r, input int c, input int off);
    @(negedge clk);
    valid_in   = 1'b1;
    conv_out_1 = CB'(pix[0][r][c] + off);
    conv_out_2 = CB'(pix[1][r][c] + off);
    conv_out_3 = CB'(pix[2][r][c] + off);
    @(posedge clk);
    #1;
    if ((r % 2 == 1) && (c % 2 == 1)) begin
      pulses++;
      checks++;
      if (valid_out_relu !== 1'b1) begin
        errors++;
        $display("FAIL %s pulse pix(%0d,%0d): valid_out_relu got %b want 1", cur_test, r, c, valid_out_relu);
      end
      for (int ch = 0; ch < 3; ch++) begin
        last_exp[ch] = expect_val(ch, r / 2, c / 2, off);
        checks++;
        if (obs[ch] !== last_exp[ch]) begin
          errors++;
          $display("FAIL %s value win(%0d,%0d) ch%0d: got %h want %h", cur_test, r / 2, c / 2, ch + 1, obs[ch], last_exp[ch]);
        end
      end
    end else begin
      check_idle_outputs(r, c);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    valid_in = 1'b0;
    @(posedge clk);
    #1;
    check_idle_outputs(-1, -1);
  endtask

  task automatic send_frame(input int gap_max, input int off);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        send_pixel(r, c, off);
        if (gap_max > 0) repeat ($urandom_range(0, gap_max)) idle_cycle();
      end
  endtask

  task automatic check_pulses(input int want);
    checks++;
    if (pulses !== want) begin
      errors++;
      $display("FAIL %s pulse_count: got %0d want %0d", cur_test, pulses, want);
    end
  endtask

  // Reset is asserted while valid_in is high, so this also checks that reset
  // takes priority over valid_in.
  task automatic test_reset();
    cur_test = "reset";
    @(negedge clk);
    rst_n      = 1'b1;
    valid_in   = 1'b1;
    conv_out_1 = 12'h123;
    repeat (2) @(posedge clk);
    #1;
    for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;
    check_idle_outputs(-1, -1);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic test_ramp();
    cur_test = "ramp";
    fill_ramp();
    // Hand-derived ch1 outputs: 8*(2i+1) + (2j+1).
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        checks++;
        if (expect_val(0, i, j, 0) !== CB'(16*i + 2*j + 9)) begin
          errors++;
          $display("FAIL ramp model win(%0d,%0d): got %0d want %0d", i, j, expect_val(0, i, j, 0), 16*i + 2*j + 9);
        end
      end
    pulses = 0;
    send_frame(0, 0);
    idle_cycle();
    check_pulses(16);
  endtask

  task automatic test_negatives_signed();
    cur_test = "negatives_signed";
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        pix[0][r][c] = ((r*5 + c*3) % 7) * 100 - 300;
        pix[1][r][c] = -128;
        pix[2][r][c] = 0;
      end
    // ch2: {-5,-3,-7,-1} -> 0 and {-5,3,-7,-1} -> 3
    pix[1][0][0] = -5; pix[1][0][1] = -3; pix[1][1][0] = -7; pix[1][1][1] = -1;
    pix[1][0][2] = -5; pix[1][0][3] =  3; pix[1][1][2] = -7; pix[1][1][3] = -1;
    // ch3: {7FF,800,0,1} -> 7FF, the mirrored window -> 7FF, all 800 -> 0
    pix[2][0][0] = 2047;  pix[2][0][1] = -2048; pix[2][1][0] = 0; pix[2][1][1] = 1;
    pix[2][0][2] = -2048; pix[2][0][3] = 0;     pix[2][1][2] = 1; pix[2][1][3] = 2047;
    for (int r = 2; r < 4; r++)
      for (int c = 2; c < 4; c++) pix[2][r][c] = -2048;
    pulses = 0;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        send_pixel(r, c, 0);
        if (r == 1 && c == 1) begin
          checks++;
          if (max_value_2 !== 12'h000 || max_value_3 !== 12'h7FF) begin
            errors++;
            $display("FAIL %s win00: ch2 got %h want 000, ch3 got %h want 7ff", cur_test, max_value_2, max_value_3);
          end
        end
        if (r == 1 && c == 3) begin
          checks++;
          if (max_value_2 !== 12'h003 || max_value_3 !== 12'h7FF) begin
            errors++;
            $display("FAIL %s win01: ch2 got %h want 003, ch3 got %h want 7ff", cur_test, max_value_2, max_value_3);
          end
        end
      end
    idle_cycle();
    check_pulses(16);
  endtask

  task automatic test_gapped();
    cur_test = "gapped";
    fill_ramp();
    pulses = 0;
    send_frame(3, 0);
    idle_cycle();
    check_pulses(16);
  endtask

  task automatic test_reset_mid_frame();
    cur_test = "reset_mid_frame";
    fill_ramp();
    for (int k = 0; k < 37; k++) send_pixel(k / 8, k % 8, 0);
    @(negedge clk);
    rst_n      = 1'b1;
    valid_in   = 1'b1;
    conv_out_1 = 12'h7FF;
    @(posedge clk);
    #1;
    for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;
    check_idle_outputs(-1, -1);
    @(negedge clk);
    rst_n    = 1'b0;
    valid_in = 1'b0;
    pulses = 0;
    send_frame(0, 0);
    idle_cycle();
    check_pulses(16);
  endtask

  task automatic test_back_to_back();
    cur_test = "back_to_back";
    fill_ramp();
    pulses = 0;
    send_frame(0, 0);
    send_frame(0, 100);
    idle_cycle();
    idle_cycle();
    check_pulses(32);
  endtask

  initial begin
    rst_n      = 1'b1;
    valid_in   = 1'b0;
    conv_out_1 = '0;
    conv_out_2 = '0;
    conv_out_3 = '0;
    pulses     = 0;
    for (int ch = 0; ch < 3; ch++) last_exp[ch] = '0;

    test_reset();
    test_ramp();
    test_negatives_signed();
    test_gapped();
    test_reset_mid_frame();
    test_back_to_back();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
